instr_fetch: RTL and testbench

Instruction fetch stage for the RISC-V core. Holds the program counter, issues one read per cycle to the synchronous instruction `rom` (one-cycle read latency), and presents the returned word with its PC to decode under a valid/stall handshake. A one-entry skid buffer absorbs the read already in flight when decode stalls. A redirect from execute (branch/jump) restarts fetch at a new PC.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/fetch_skid.sv | 34 +++
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared core constants and types for the fetch stage.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    // Word address presented to the instruction memory for a byte PC.
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_pc);
        return {2'b00, byte_pc[XLEN-1:2]};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched word and its PC.
// A clear wins over a simultaneous load.
module fetch_skid
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DWIDTH = ILEN
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              load,
    input  logic              clear,
    input  logic [DWIDTH-1:0] load_data,
    input  logic [XLEN-1:0]   load_pc,
    output logic              valid,
    output logic [DWIDTH-1:0] data,
    output logic [XLEN-1:0]   pc
);

    // Capture or drop the held entry.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-cycle ROM read pipeline, skid buffer,
// valid/stall handshake to decode and redirect from execute.
// Optional build macro: FETCH_MISALIGN_EN adds the sticky fetch_misalign
// output and ignores redirects to non-word-aligned targets.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     DWIDTH   = ILEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              romR,
    output logic [XLEN-1:0]   romAddr,
    input  logic [DWIDTH-1:0] romData,
    output logic [DWIDTH-1:0] instr,
    output logic [XLEN-1:0]   instr_pc,
`ifdef FETCH_MISALIGN_EN
    output logic              fetch_misalign,
`endif
    output logic              instr_valid
);

    fetch_state_t      state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic              inflight, inflight_n;
    logic [XLEN-1:0]   inflight_pc, inflight_pc_n;
    logic [DWIDTH-1:0] instr_n;
    logic [XLEN-1:0]   instr_pc_n;
    logic              instr_valid_n;

    logic              skid_load, skid_clear, skid_valid;
    logic [DWIDTH-1:0] skid_data;
    logic [XLEN-1:0]   skid_pc;

    logic              take_redirect;
    logic [XLEN-1:0]   target;

    assign target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_EN
    logic bad_redirect;

    assign bad_redirect  = redirect && (redirect_pc[1:0] != 2'b00);
    assign take_redirect = redirect && !bad_redirect;

    // Sticky flag for a rejected misaligned redirect.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            fetch_misalign <= 1'b0;
        end else if (bad_redirect) begin
            fetch_misalign <= 1'b1;
        end
    end
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign take_redirect        = redirect;
`endif

    // Issue a read unless redirecting, holding a valid output, or skid is full.
    assign romR    = !take_redirect && !(stall && instr_valid) && !skid_valid;
    assign romAddr = word_addr(pc);

    fetch_skid #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clock     (clock),
        .nreset    (nreset),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (romData),
        .load_pc   (inflight_pc),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, PC, read pipeline and output selection.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        inflight_n    = 1'b0;
        inflight_pc_n = inflight_pc;
        instr_n       = instr;
        instr_pc_n    = instr_pc;
        instr_valid_n = instr_valid;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;

        if (romR) begin
            pc_n          = pc + PC_STEP;
            inflight_n    = 1'b1;
            inflight_pc_n = pc;
        end

        if (take_redirect) begin
            pc_n          = target;
            inflight_n    = 1'b0;
            skid_clear    = 1'b1;
            instr_valid_n = 1'b0;
            state_n       = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (stall && instr_valid) begin
                        state_n   = HOLD;
                        skid_load = inflight;
                    end else if (inflight) begin
                        instr_n       = romData;
                        instr_pc_n    = inflight_pc;
                        instr_valid_n = 1'b1;
                    end else begin
                        instr_valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_n = RUN;
                        if (skid_valid) begin
                            instr_n       = skid_data;
                            instr_pc_n    = skid_pc;
                            instr_valid_n = 1'b1;
                            skid_clear    = 1'b1;
                        end else begin
                            instr_valid_n = 1'b0;
                        end
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    // PC, in-flight tracking and decode-facing output registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            pc          <= pc_n;
            inflight    <= inflight_n;
            inflight_pc <= inflight_pc_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= instr_valid_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a one-cycle ROM model.
// ROM word at word address a is (a[3:0]+1)*17: 0x11,0x22,...,0xFF,0x110.
module tb_instr_fetch;

    logic        clock;
    logic        nreset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        romR;
    logic [31:0] romAddr;
    logic [31:0] romData;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_misalign;
`endif

    int errors = 0;
    int checks = 0;

    instr_fetch dut (
        .clock          (clock),
        .nreset         (nreset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .romR           (romR),
        .romAddr        (romAddr),
        .romData        (romData),
        .instr          (instr),
        .instr_pc       (instr_pc),
`ifdef FETCH_MISALIGN_EN
        .fetch_misalign (fetch_misalign),
`endif
        .instr_valid    (instr_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (32'(a[3:0]) + 32'd1) * 32'd17;
    endfunction

    always @(posedge clock) begin
        if (romR) romData <= word_of(romAddr);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        nreset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        logic [64:0] got;
        nreset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clock);
        #1;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== 65'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", got, 65'h0);
        end
        nreset = 1'b1;
        #1;
        checks++;
        if ({romR, romAddr} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL reset_first_fetch: got %b/%h want 1/00000000", romR, romAddr);
        end
        tick;
        checks++;
        if ({instr_valid, romAddr} !== {1'b0, 32'h1}) begin
            errors++; $display("FAIL reset_edge1: got valid=%b addr=%h want 0/00000001", instr_valid, romAddr);
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h0, 32'h11}) begin
            errors++; $display("FAIL reset_edge2: got %h want %h", got, {1'b1, 32'h0, 32'h11});
        end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_i [4];
        logic [64:0] got;
        exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33; exp_i[3] = 32'h44;
        do_reset;
        tick;
        for (int k = 0; k < 4; k++) begin
            tick;
            got = {instr_valid, instr_pc, instr};
            checks++;
            if (got !== {1'b1, 32'(k * 4), exp_i[k]}) begin
                errors++; $display("FAIL seq_word%0d: got %h want %h", k, got, {1'b1, 32'(k * 4), exp_i[k]});
            end
        end
    endtask

    task automatic test_stall;
        logic [64:0] got;
        logic [31:0] want_pc [2];
        logic [31:0] want_i [2];
        bit          seen;
        want_pc[0] = 32'hC;  want_i[0] = 32'h44;
        want_pc[1] = 32'h10; want_i[1] = 32'h55;
        do_reset;
        repeat (3) tick;
        stall = 1'b1;
        #1;
        checks++;
        if (romR !== 1'b0) begin
            errors++; $display("FAIL stall_romr_first: got %b want 0", romR);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            got = {instr_valid, instr_pc, instr};
            checks++;
            if (got !== {1'b1, 32'h4, 32'h22} || romR !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got %h romR=%b want %h romR=0", k, got, romR, {1'b1, 32'h4, 32'h22});
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (romR !== 1'b0) begin
            errors++; $display("FAIL stall_release_romr: got %b want 0", romR);
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h8, 32'h33}) begin
            errors++; $display("FAIL stall_skid_word: got %h want %h", got, {1'b1, 32'h8, 32'h33});
        end
        for (int n = 0; n < 2; n++) begin
            seen = 1'b0;
            for (int k = 0; k < 3 && !seen; k++) begin
                tick;
                seen = instr_valid;
            end
            got = {instr_valid, instr_pc, instr};
            checks++;
            if (got !== {1'b1, want_pc[n], want_i[n]}) begin
                errors++; $display("FAIL stall_after%0d: got %h want %h", n, got, {1'b1, want_pc[n], want_i[n]});
            end
        end
    endtask

    task automatic test_redirect;
        logic [64:0] got;
        do_reset;
        repeat (3) tick;
        redirect = 1'b1; redirect_pc = 32'h10;
        #1;
        checks++;
        if (romR !== 1'b0) begin
            errors++; $display("FAIL redir_romr: got %b want 0", romR);
        end
        tick;
        redirect = 1'b0;
        #1;
        checks++;
        if ({instr_valid, romR, romAddr} !== {1'b0, 1'b1, 32'h4}) begin
            errors++; $display("FAIL redir_bubble1: got v=%b r=%b a=%h want 0/1/00000004", instr_valid, romR, romAddr);
        end
        tick;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL redir_bubble2: got %b want 0", instr_valid);
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h10, 32'h55}) begin
            errors++; $display("FAIL redir_target: got %h want %h", got, {1'b1, 32'h10, 32'h55});
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h14, 32'h66}) begin
            errors++; $display("FAIL redir_next: got %h want %h", got, {1'b1, 32'h14, 32'h66});
        end
    endtask

    task automatic test_redirect_stall;
        logic [64:0] got;
        do_reset;
        repeat (3) tick;
        stall = 1'b1;
        tick;
        redirect = 1'b1; redirect_pc = 32'h20;
        #1;
        checks++;
        if (romR !== 1'b0) begin
            errors++; $display("FAIL rs_romr: got %b want 0", romR);
        end
        tick;
        redirect = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if ({instr_valid, romR, romAddr} !== {1'b0, 1'b1, 32'h8}) begin
            errors++; $display("FAIL rs_restart: got v=%b r=%b a=%h want 0/1/00000008", instr_valid, romR, romAddr);
        end
        tick;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL rs_bubble: got %b want 0", instr_valid);
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h20, 32'h99}) begin
            errors++; $display("FAIL rs_target: got %h want %h", got, {1'b1, 32'h20, 32'h99});
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h24, 32'hAA}) begin
            errors++; $display("FAIL rs_next: got %h want %h", got, {1'b1, 32'h24, 32'hAA});
        end
    endtask

    task automatic test_wrap;
        logic [64:0] got;
        do_reset;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect = 1'b0;
        #1;
        checks++;
        if ({romR, romAddr} !== {1'b1, 32'h3FFF_FFFF}) begin
            errors++; $display("FAIL wrap_top_addr: got %b/%h want 1/3fffffff", romR, romAddr);
        end
        tick;
        checks++;
        if ({romR, romAddr} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL wrap_zero_addr: got %b/%h want 1/00000000", romR, romAddr);
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'hFFFF_FFFC, 32'h110}) begin
            errors++; $display("FAIL wrap_top_word: got %h want %h", got, {1'b1, 32'hFFFF_FFFC, 32'h110});
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h0, 32'h11}) begin
            errors++; $display("FAIL wrap_zero_word: got %h want %h", got, {1'b1, 32'h0, 32'h11});
        end
    endtask

    task automatic test_misalign;
        logic [64:0] got;
        do_reset;
        repeat (2) tick;
        redirect = 1'b1; redirect_pc = 32'h13;
`ifdef FETCH_MISALIGN_EN
        tick;
        redirect = 1'b0;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h4, 32'h22} || fetch_misalign !== 1'b1) begin
            errors++; $display("FAIL mis_flag: got %h flag=%b want %h flag=1", got, fetch_misalign, {1'b1, 32'h4, 32'h22});
        end
        tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h8, 32'h33} || fetch_misalign !== 1'b1) begin
            errors++; $display("FAIL mis_continue: got %h flag=%b want %h flag=1", got, fetch_misalign, {1'b1, 32'h8, 32'h33});
        end
`else
        tick;
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL mis_bubble: got %b want 0", instr_valid);
        end
        repeat (2) tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h10, 32'h55}) begin
            errors++; $display("FAIL mis_truncate: got %h want %h", got, {1'b1, 32'h10, 32'h55});
        end
`endif
    endtask

    task automatic test_reset_mid;
        logic [64:0] got;
        do_reset;
        repeat (3) tick;
        stall = 1'b1;
        tick;
        #2;
        nreset = 1'b0;
        #1;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== 65'h0 || {romR, romAddr} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL midreset_clear: got %h r=%b a=%h want 0 r=1 a=00000000", got, romR, romAddr);
        end
        stall = 1'b0;
        tick;
        nreset = 1'b1;
        #1;
        repeat (2) tick;
        got = {instr_valid, instr_pc, instr};
        checks++;
        if (got !== {1'b1, 32'h0, 32'h11}) begin
            errors++; $display("FAIL midreset_restart: got %h want %h", got, {1'b1, 32'h0, 32'h11});
        end
    endtask

    initial begin
        nreset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        test_reset;
        test_sequential;
        test_stall;
        test_redirect;
        test_redirect_stall;
        test_wrap;
        test_misalign;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
